// File: rtl/vga_ball_engine.sv
// VGA timing generator with a ball that moves once per frame and bounces off the visible-area borders.
// Counters start at the beginning of sync; video outputs are registered one cycle behind the counters.
module vga_ball_engine #(
    parameter int unsigned H         = 640,
    parameter int unsigned HFP       = 24,
    parameter int unsigned HS        = 40,
    parameter int unsigned HBP       = 128,
    parameter int unsigned V         = 480,
    parameter int unsigned VFP       = 9,
    parameter int unsigned VS        = 2,
    parameter int unsigned VBP       = 29,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CW        = 11,
    parameter int unsigned BALL_SIZE = 16,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned CD        = 6
) (
    input  logic          pixel_clock,
    input  logic          reset_n,
    input  logic          run,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic [CD-1:0] VGA_R,
    output logic [CD-1:0] VGA_G,
    output logic [CD-1:0] VGA_B,
    output logic          de,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          frame_tick
);

    localparam int unsigned EW    = CW + 1;
    localparam int unsigned HT    = HS + HBP + H + HFP;
    localparam int unsigned VT    = VS + VBP + V + VFP;
    localparam int unsigned XL    = HS + HBP;
    localparam int unsigned XR    = XL + H;
    localparam int unsigned YT    = VS + VBP;
    localparam int unsigned YB    = YT + V;
    localparam int unsigned X_MIN = XL;
    localparam int unsigned X_MAX = XR - BALL_SIZE;
    localparam int unsigned Y_MIN = YT;
    localparam int unsigned Y_MAX = YB - BALL_SIZE;
    localparam int unsigned X_CTR = X_MIN + (H - BALL_SIZE) / 2;
    localparam int unsigned Y_CTR = Y_MIN + (V - BALL_SIZE) / 2;

    typedef logic [EW-1:0] ext_t;

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, pix_q, pix_d;
    ext_t          hx, vy;
    logic          visible, ball_hit;

    // One axis of the bounce: returns {new_dir, new_pos}, arithmetic one bit wider than the counters.
    function automatic logic [CW:0] bounce(input logic [CW-1:0] pos, input logic dir,
                                           input logic [CW-1:0] lo, input logic [CW-1:0] hi);
        ext_t        p_e, s_e, lo_e, hi_e;
        logic [CW:0] r;
        p_e  = EW'(pos);
        s_e  = EW'(SPEED);
        lo_e = EW'(lo);
        hi_e = EW'(hi);
        if (dir) begin
            if (p_e + s_e >= hi_e) r = {1'b0, hi};
            else                   r = {1'b1, CW'(p_e + s_e)};
        end else begin
            if (p_e <= lo_e + s_e) r = {1'b1, lo};
            else                   r = {1'b0, CW'(p_e - s_e)};
        end
        return r;
    endfunction

    assign hx         = EW'(h_q);
    assign vy         = EW'(v_q);
    assign frame_tick = (h_q == '0) && (v_q == '0);
    assign visible    = (hx >= EW'(XL)) && (hx < EW'(XR)) && (vy >= EW'(YT)) && (vy < EW'(YB));
    assign ball_hit   = visible
                      && (hx >= EW'(ball_x_q)) && (hx < EW'(ball_x_q) + EW'(BALL_SIZE))
                      && (vy >= EW'(ball_y_q)) && (vy < EW'(ball_y_q) + EW'(BALL_SIZE));

    // Pixel/line counters; the line counter steps when the pixel counter wraps.
    always_comb begin
        h_d = h_q + CW'(1);
        v_d = v_q;
        if (h_q == CW'(HT - 1)) begin
            h_d = '0;
            v_d = (v_q == CW'(VT - 1)) ? '0 : v_q + CW'(1);
        end
    end

    // Ball moves only at frame start, so its position is stable for the whole frame.
    always_comb begin
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        if (frame_tick && run) begin
            {dir_x_d, ball_x_d} = bounce(ball_x_q, dir_x_q, CW'(X_MIN), CW'(X_MAX));
            {dir_y_d, ball_y_d} = bounce(ball_y_q, dir_y_q, CW'(Y_MIN), CW'(Y_MAX));
        end
    end

    always_comb begin
        hs_d  = (hx < EW'(HS)) ? HS_POL : ~HS_POL;
        vs_d  = (vy < EW'(VS)) ? VS_POL : ~VS_POL;
        de_d  = visible;
        pix_d = ball_hit;
    end

    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            h_q      <= '0;
            v_q      <= '0;
            ball_x_q <= CW'(X_CTR);
            ball_y_q <= CW'(Y_CTR);
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            hs_q     <= HS_POL;
            vs_q     <= VS_POL;
            de_q     <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            pix_q    <= pix_d;
        end
    end

    assign h_cnt  = h_q;
    assign v_cnt  = v_q;
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;
    assign de     = de_q;
    assign VGA_R  = {CD{pix_q}};
    assign VGA_G  = {CD{pix_q}};
    assign VGA_B  = {CD{pix_q}};

endmodule

// File: tb/tb_vga_ball_engine.sv
// Directed bench: default 640x480 timing (A), small bounce geometry (B), and a smaller
// active-high-sync instance (C) whose low-side clamps, run gating and mid-frame reset are exercised.
module tb_vga_ball_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    // Instance A: defaults
    logic        rst_a, run_a, a_hs, a_vs, a_de, a_ft;
    logic [5:0]  a_r, a_g, a_b;
    logic [10:0] a_h, a_v;
    // Instance B: H=64 V=48, porches/syncs 4, ball 8, speed 3
    logic        rst_b, run_b, b_hs, b_vs, b_de, b_ft;
    logic [5:0]  b_r, b_g, b_b;
    logic [7:0]  b_h, b_v;
    // Instance C: H=34 V=24, porches/syncs 4, ball 8, speed 3, active-high syncs
    logic        rst_c, run_c, c_hs, c_vs, c_de, c_ft;
    logic [3:0]  c_r, c_g, c_b;
    logic [6:0]  c_h, c_v;

    vga_ball_engine dut_a (
        .pixel_clock(clk), .reset_n(rst_a), .run(run_a), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .de(a_de), .h_cnt(a_h), .v_cnt(a_v), .frame_tick(a_ft));

    vga_ball_engine #(
        .H(64), .HFP(4), .HS(4), .HBP(4), .V(48), .VFP(4), .VS(4), .VBP(4),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(8), .BALL_SIZE(8), .SPEED(3), .CD(6)
    ) dut_b (
        .pixel_clock(clk), .reset_n(rst_b), .run(run_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .de(b_de), .h_cnt(b_h), .v_cnt(b_v), .frame_tick(b_ft));

    vga_ball_engine #(
        .H(34), .HFP(4), .HS(4), .HBP(4), .V(24), .VFP(4), .VS(4), .VBP(4),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(7), .BALL_SIZE(8), .SPEED(3), .CD(4)
    ) dut_c (
        .pixel_clock(clk), .reset_n(rst_c), .run(run_c), .VGA_HS(c_hs), .VGA_VS(c_vs),
        .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .de(c_de), .h_cnt(c_h), .v_cnt(c_v), .frame_tick(c_ft));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        run_a = 1'b1; run_b = 1'b1; run_c = 1'b1;
        repeat (3) step();
        compared++; if (a_h !== 11'd0) begin failed++; $display("FAIL reset_h_cnt: got %0d expected 0", a_h); end
        compared++; if (a_v !== 11'd0) begin failed++; $display("FAIL reset_v_cnt: got %0d expected 0", a_v); end
        compared++; if ({a_hs, a_vs} !== 2'b00) begin failed++; $display("FAIL reset_sync: got %b expected 00", {a_hs, a_vs}); end
        compared++; if ({a_r, a_g, a_b} !== 18'd0) begin failed++; $display("FAIL reset_rgb: got %h expected 0", {a_r, a_g, a_b}); end
        compared++; if (a_de !== 1'b0) begin failed++; $display("FAIL reset_de: got %b expected 0", a_de); end
        // centre = X_MIN + (H-BALL)/2 = 168+312, Y_MIN + (V-BALL)/2 = 31+232
        compared++; if (dut_a.ball_x_q !== 11'd480) begin failed++; $display("FAIL reset_ball_x: got %0d expected 480", dut_a.ball_x_q); end
        compared++; if (dut_a.ball_y_q !== 11'd263) begin failed++; $display("FAIL reset_ball_y: got %0d expected 263", dut_a.ball_y_q); end
        compared++; if ({dut_a.dir_x_q, dut_a.dir_y_q} !== 2'b11) begin failed++; $display("FAIL reset_dir: got %b expected 11", {dut_a.dir_x_q, dut_a.dir_y_q}); end
        rst_a = 1'b1;
        compared++; if (a_ft !== 1'b1) begin failed++; $display("FAIL reset_frame_tick: got %b expected 1", a_ft); end
    endtask

    task automatic test_sync_default();
        int hs_lo = 0;
        int vs_lo = 0;
        for (int i = 0; i < 3 * 832; i++) begin
            step();
            if (a_hs == 1'b0) hs_lo++;
            if (a_vs == 1'b0) vs_lo++;
        end
        compared++; if (hs_lo != 120) begin failed++; $display("FAIL hs_low_3_lines: got %0d expected 120", hs_lo); end
        compared++; if (vs_lo != 1664) begin failed++; $display("FAIL vs_low_first_lines: got %0d expected 1664", vs_lo); end
        compared++; if ({a_h, a_v} !== {11'd0, 11'd3}) begin failed++; $display("FAIL counters_after_3_lines: got h=%0d v=%0d expected h=0 v=3", a_h, a_v); end
        compared++; if ({dut_a.ball_x_q, dut_a.ball_y_q} !== {11'd482, 11'd265}) begin failed++; $display("FAIL first_update: got (%0d,%0d) expected (482,265)", dut_a.ball_x_q, dut_a.ball_y_q); end
    endtask

    task automatic test_bounce_right_bottom();
        int ex [11];
        int ey [11];
        int ed [11];
        int n, de_n, pix_n, bad;
        ex = '{39, 42, 45, 48, 51, 54, 57, 60, 63, 64, 61};
        ey = '{31, 34, 37, 40, 43, 46, 48, 45, 42, 39, 36};
        ed = '{3, 3, 3, 3, 3, 3, 2, 2, 2, 0, 0};
        bad = 0;
        compared++; if ({dut_b.ball_x_q, dut_b.ball_y_q} !== {8'd36, 8'd28}) begin failed++; $display("FAIL b_reset_ball: got (%0d,%0d) expected (36,28)", dut_b.ball_x_q, dut_b.ball_y_q); end
        compared++; if ({b_hs, b_vs, b_h, b_v} !== 18'd0) begin failed++; $display("FAIL b_reset_outputs: got hs=%b vs=%b h=%0d v=%0d expected all 0", b_hs, b_vs, b_h, b_v); end
        rst_b = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin
                n = 1; de_n = 0; pix_n = 0;
                do begin
                    step();
                    n++;
                    if (b_de) de_n++;
                    if ({b_r, b_g, b_b} != 18'd0) begin
                        pix_n++;
                        if ({b_r, b_g, b_b} != 18'h3ffff) bad++;
                    end
                end while (!b_ft && n < 10000);
                compared++; if (n != 4560) begin failed++; $display("FAIL b_frame_period[%0d]: got %0d expected 4560", k, n); end
                compared++; if (de_n != 3072) begin failed++; $display("FAIL b_de_per_frame[%0d]: got %0d expected 3072", k, de_n); end
                compared++; if (pix_n != 64) begin failed++; $display("FAIL b_ball_pixels[%0d]: got %0d expected 64", k, pix_n); end
            end
            step();
            compared++; if (dut_b.ball_x_q !== 8'(ex[k])) begin failed++; $display("FAIL b_ball_x[%0d]: got %0d expected %0d", k, dut_b.ball_x_q, ex[k]); end
            compared++; if (dut_b.ball_y_q !== 8'(ey[k])) begin failed++; $display("FAIL b_ball_y[%0d]: got %0d expected %0d", k, dut_b.ball_y_q, ey[k]); end
            compared++; if ({dut_b.dir_x_q, dut_b.dir_y_q} !== 2'(ed[k])) begin failed++; $display("FAIL b_dir[%0d]: got %b expected %b", k, {dut_b.dir_x_q, dut_b.dir_y_q}, 2'(ed[k])); end
        end
        compared++; if (bad != 0) begin failed++; $display("FAIL b_rgb_level: got %0d non-white ball pixels expected 0", bad); end
    endtask

    task automatic test_de_default();
        int n = 0;
        int ones = 0;
        while (a_h != 11'd168 && n < 1000) begin
            step();
            n++;
        end
        compared++; if (a_h !== 11'd168 || a_v < 11'd31 || a_v >= 11'd511) begin failed++; $display("FAIL de_line_reach: got h=%0d v=%0d expected h=168 on a visible line", a_h, a_v); end
        compared++; if (a_de !== 1'b0) begin failed++; $display("FAIL de_before_window: got %b expected 0", a_de); end
        for (int i = 0; i < 641; i++) begin
            step();
            if (a_de) ones++;
        end
        compared++; if (ones != 640) begin failed++; $display("FAIL de_width: got %0d expected 640", ones); end
        compared++; if (a_de !== 1'b0) begin failed++; $display("FAIL de_after_window: got %b expected 0", a_de); end
    endtask

    task automatic test_bounce_left_top();
        int ex [15];
        int ey [15];
        int ed [15];
        int n, de_n, pix_n;
        ex = '{24, 27, 30, 33, 34, 31, 28, 25, 22, 19, 16, 13, 10, 8, 11};
        ey = '{19, 22, 24, 21, 18, 15, 12, 9, 8, 11, 14, 17, 20, 23, 24};
        ed = '{3, 3, 2, 2, 0, 0, 0, 0, 1, 1, 1, 1, 1, 3, 2};
        compared++; if ({dut_c.ball_x_q, dut_c.ball_y_q} !== {7'd21, 7'd16}) begin failed++; $display("FAIL c_reset_ball: got (%0d,%0d) expected (21,16)", dut_c.ball_x_q, dut_c.ball_y_q); end
        compared++; if ({c_hs, c_vs} !== 2'b11) begin failed++; $display("FAIL c_reset_sync_pol: got %b expected 11", {c_hs, c_vs}); end
        rst_c = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) begin
                n = 1; de_n = 0; pix_n = 0;
                do begin
                    step();
                    n++;
                    if (c_de) de_n++;
                    if (c_r == 4'hf && c_g == 4'hf && c_b == 4'hf) pix_n++;
                end while (!c_ft && n < 10000);
                compared++; if (n != 1656) begin failed++; $display("FAIL c_frame_period[%0d]: got %0d expected 1656", k, n); end
                compared++; if (de_n != 816 || pix_n != 64) begin failed++; $display("FAIL c_frame_pixels[%0d]: got de=%0d ball=%0d expected de=816 ball=64", k, de_n, pix_n); end
            end
            step();
            compared++; if (dut_c.ball_x_q !== 7'(ex[k])) begin failed++; $display("FAIL c_ball_x[%0d]: got %0d expected %0d", k, dut_c.ball_x_q, ex[k]); end
            compared++; if (dut_c.ball_y_q !== 7'(ey[k])) begin failed++; $display("FAIL c_ball_y[%0d]: got %0d expected %0d", k, dut_c.ball_y_q, ey[k]); end
            compared++; if ({dut_c.dir_x_q, dut_c.dir_y_q} !== 2'(ed[k])) begin failed++; $display("FAIL c_dir[%0d]: got %b expected %b", k, {dut_c.dir_x_q, dut_c.dir_y_q}, 2'(ed[k])); end
        end
    endtask

    task automatic test_run_freeze();
        int ticks = 0;
        int hs_act = 0;
        int vs_act = 0;
        int n = 0;
        run_c = 1'b0;
        for (int i = 0; i < 3 * 1656; i++) begin
            if (i == 100) run_c = 1'b1;
            if (i == 1500) run_c = 1'b0;
            step();
            if (c_ft) ticks++;
            if (c_hs) hs_act++;
            if (c_vs) vs_act++;
        end
        compared++; if (ticks != 3) begin failed++; $display("FAIL freeze_ticks: got %0d expected 3", ticks); end
        compared++; if (hs_act != 432 || vs_act != 552) begin failed++; $display("FAIL freeze_sync: got hs=%0d vs=%0d expected hs=432 vs=552", hs_act, vs_act); end
        compared++; if ({dut_c.ball_x_q, dut_c.ball_y_q} !== {7'd11, 7'd24}) begin failed++; $display("FAIL freeze_ball: got (%0d,%0d) expected (11,24)", dut_c.ball_x_q, dut_c.ball_y_q); end
        run_c = 1'b1;
        while (!c_ft && n < 2000) begin
            step();
            n++;
        end
        step();
        compared++; if ({dut_c.ball_x_q, dut_c.ball_y_q} !== {7'd14, 7'd21}) begin failed++; $display("FAIL resume_ball: got (%0d,%0d) expected (14,21)", dut_c.ball_x_q, dut_c.ball_y_q); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (!(c_h == 7'd20 && c_v == 7'd30) && n < 4000) begin
            step();
            n++;
        end
        compared++; if ({c_h, c_v} !== {7'd20, 7'd30}) begin failed++; $display("FAIL mid_reset_reach: got h=%0d v=%0d expected h=20 v=30", c_h, c_v); end
        rst_c = 1'b0;
        step();
        rst_c = 1'b1;
        compared++; if ({c_h, c_v} !== 14'd0) begin failed++; $display("FAIL mid_reset_counters: got h=%0d v=%0d expected 0 0", c_h, c_v); end
        compared++; if ({dut_c.ball_x_q, dut_c.ball_y_q} !== {7'd21, 7'd16}) begin failed++; $display("FAIL mid_reset_ball: got (%0d,%0d) expected (21,16)", dut_c.ball_x_q, dut_c.ball_y_q); end
        compared++; if ({dut_c.dir_x_q, dut_c.dir_y_q} !== 2'b11) begin failed++; $display("FAIL mid_reset_dir: got %b expected 11", {dut_c.dir_x_q, dut_c.dir_y_q}); end
        compared++; if ({c_hs, c_vs, c_de, c_r, c_g, c_b} !== {1'b1, 1'b1, 1'b0, 12'd0}) begin failed++; $display("FAIL mid_reset_outputs: got hs=%b vs=%b de=%b rgb=%h expected 1 1 0 0", c_hs, c_vs, c_de, {c_r, c_g, c_b}); end
        compared++; if (c_ft !== 1'b1) begin failed++; $display("FAIL mid_reset_tick: got %b expected 1", c_ft); end
        step();
        compared++; if ({dut_c.ball_x_q, dut_c.ball_y_q} !== {7'd24, 7'd19}) begin failed++; $display("FAIL mid_reset_first_update: got (%0d,%0d) expected (24,19)", dut_c.ball_x_q, dut_c.ball_y_q); end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
        test_reset();
        test_sync_default();
        test_bounce_right_bottom();
        test_de_default();
        test_bounce_left_top();
        test_run_freeze();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
